// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared pipeline constants, stage and ALU codes
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] LINK_OFFSET      = 32'd8;
    localparam logic [31:0] WORD_ALIGN_MASK  = ~(WORD_BYTES - 32'd1);

    typedef enum logic [2:0] {
        STAGE_F,
        STAGE_D,
        STAGE_E,
        STAGE_M,
        STAGE_W
    } stage_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + LINK_OFFSET;
    endfunction

endpackage

// File: rtl/fetch_unit_fd_pipe_reg.sv
// rtl/fetch_unit_fd_pipe_reg.sv - F/D pipeline register with bubble insertion
module fd_pipe_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        insert_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        bubble_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        bubble_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        bubble_q, bubble_d;

    // An inserted bubble still takes pc_i so the caller decides what pc a bubble carries
    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        bubble_d = bubble_q;
        if (load_i) begin
            pc_d = pc_i;
            if (insert_i) begin
                instr_d  = 32'h0;
                bubble_d = 1'b1;
            end else begin
                instr_d  = instr_i;
                bubble_d = bubble_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= 32'h0;
            pc_q     <= RESET_PC;
            bubble_q <= 1'b1;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            bubble_q <= bubble_d;
        end
    end

    assign instr_o  = instr_q;
    assign pc_o     = pc_q;
    assign bubble_o = bubble_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, halt latch, counters, F/D register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    input  logic        halt,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc8D,
    output logic        bubbleD,
    output logic        halted,
    output logic [31:0] fetchCount,
    output logic        imemRangeErr
);

    logic [31:0] pc_q, pc_d;
    logic        halted_q, halted_d;
    logic        range_err_q, range_err_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        halting;
    logic        advance;
    logic        out_of_range;
    logic [31:0] word_offset;

    always_comb begin
        halting       = halt || halted_q;
        advance       = !stall && !halting;
        // Unsigned wrap makes addresses below RESET_PC land far out of range
        word_offset   = (pc_q - RESET_PC) >> 2;
        out_of_range  = word_offset >= 32'(IMEM_WORDS);

        pc_d          = pc_q;
        halted_d      = halted_q || (!stall && halt);
        range_err_d   = range_err_q || (advance && out_of_range);
        fetch_count_d = fetch_count_q;

        if (advance) begin
            pc_d = redirect ? (redirectTarget & WORD_ALIGN_MASK) : (pc_q + WORD_BYTES);
            if (!out_of_range && fetch_count_q != 32'hFFFF_FFFF) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            halted_q      <= 1'b0;
            range_err_q   <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            halted_q      <= halted_d;
            range_err_q   <= range_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Halt bubbles keep pcD; range-error bubbles record the faulting PC
    fd_pipe_reg #(
        .RESET_PC (RESET_PC)
    ) u_fd (
        .clk      (clk),
        .reset    (reset),
        .load_i   (!stall),
        .insert_i (halting || out_of_range),
        .instr_i  (imemData),
        .pc_i     (halting ? pcD : pc_q),
        .bubble_i (1'b0),
        .instr_o  (instrD),
        .pc_o     (pcD),
        .bubble_o (bubbleD)
    );

    assign imemAddr     = pc_q;
    assign pc8D         = link_addr(pcD);
    assign halted       = halted_q;
    assign fetchCount   = fetch_count_q;
    assign imemRangeErr = range_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, halt;
    logic [31:0] redirect_target;

    logic [31:0] a_addr, a_data, a_instr, a_pcd, a_pc8, a_cnt;
    logic        a_bub, a_halted, a_err;
    logic [31:0] b_addr, b_data, b_instr, b_pcd, b_pc8, b_cnt;
    logic        b_bub, b_halted, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        return 32'h11 * (((addr - RPC) >> 2) + 32'd1);
    endfunction

    assign a_data = imem(a_addr);
    assign b_data = imem(b_addr);

    fetch_unit #(.RESET_PC(RPC), .IMEM_WORDS(1024)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirectTarget(redirect_target), .halt(halt), .imemAddr(a_addr),
        .imemData(a_data), .instrD(a_instr), .pcD(a_pcd), .pc8D(a_pc8),
        .bubbleD(a_bub), .halted(a_halted), .fetchCount(a_cnt), .imemRangeErr(a_err)
    );

    fetch_unit #(.RESET_PC(RPC), .IMEM_WORDS(4)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirectTarget(redirect_target), .halt(halt), .imemAddr(b_addr),
        .imemData(b_data), .instrD(b_instr), .pcD(b_pcd), .pc8D(b_pc8),
        .bubbleD(b_bub), .halted(b_halted), .fetchCount(b_cnt), .imemRangeErr(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 60)
                $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: architectural state of the fetch stage as plain values
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        bub;
        logic        halted;
        logic [31:0] cnt;
        logic        err;
    } mstate_t;

    function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic stl,
                                           input logic hlt, input logic rdr,
                                           input logic [31:0] tgt, input int unsigned words);
        mstate_t n = s;
        longint unsigned offset;
        if (rst) begin
            n.pc = RPC; n.instr = 0; n.pcd = RPC; n.bub = 1;
            n.halted = 0; n.cnt = 0; n.err = 0;
        end else if (stl) begin
            n = s;
        end else if (hlt || s.halted) begin
            n.halted = 1; n.instr = 0; n.bub = 1;
        end else begin
            offset = longint'((s.pc - RPC) / 4);
            if (offset >= longint'(words)) begin
                n.err = 1; n.instr = 0; n.bub = 1; n.pcd = s.pc;
            end else begin
                n.instr = imem(s.pc); n.pcd = s.pc; n.bub = 0;
                if (s.cnt != 32'hFFFF_FFFF) n.cnt = s.cnt + 1;
            end
            n.pc = rdr ? {tgt[31:2], 2'b00} : s.pc + 4;
        end
        return n;
    endfunction

    task automatic cmp(input string tag, input mstate_t m, input logic [31:0] addr,
                       input logic [31:0] instr, input logic [31:0] pcd, input logic [31:0] pc8,
                       input logic bub, input logic hlt_o, input logic [31:0] cnt, input logic err);
        chk({tag, ".imemAddr"}, addr, m.pc);
        chk({tag, ".instrD"}, instr, m.instr);
        chk({tag, ".pcD"}, pcd, m.pcd);
        chk({tag, ".pc8D"}, pc8, m.pcd + 32'd8);
        chk({tag, ".bubbleD"}, 32'(bub), 32'(m.bub));
        chk({tag, ".halted"}, 32'(hlt_o), 32'(m.halted));
        chk({tag, ".fetchCount"}, cnt, m.cnt);
        chk({tag, ".imemRangeErr"}, 32'(err), 32'(m.err));
    endtask

    typedef struct {
        logic        rst, stl, hlt, rdr;
        logic [31:0] tgt;
        logic [31:0] e_addr, e_pcd, e_instr;
        logic        e_bub, e_halted;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stl, input logic hlt, input logic rdr,
                       input logic [31:0] tgt, input logic [31:0] e_addr, input logic [31:0] e_pcd,
                       input logic [31:0] e_instr, input logic e_bub, input logic e_halted,
                       input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.hlt = hlt; v.rdr = rdr; v.tgt = tgt;
        v.e_addr = e_addr; v.e_pcd = e_pcd; v.e_instr = e_instr;
        v.e_bub = e_bub; v.e_halted = e_halted; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic stl, input logic hlt, input logic rdr,
                         input logic [31:0] tgt);
        reset = rst; stall = stl; halt = hlt; redirect = rdr; redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    mstate_t m_a, m_b;

    initial begin
        reset = 1; stall = 0; halt = 0; redirect = 0; redirect_target = 0;

        //   rst stl hlt rdr tgt            addr         pcD          instr          bub hlt cnt
        add(1, 0, 0, 0, 32'h0,        32'h3000, 32'h3000, 32'h0,         1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h3004, 32'h3000, 32'h11,        0, 0, 1);
        add(0, 0, 0, 0, 32'h0,        32'h3008, 32'h3004, 32'h22,        0, 0, 2);
        add(0, 0, 0, 1, 32'h3100,     32'h3100, 32'h3008, 32'h33,        0, 0, 3);
        add(0, 0, 0, 0, 32'h0,        32'h3104, 32'h3100, imem(32'h3100), 0, 0, 4);
        add(0, 1, 0, 1, 32'h3200,     32'h3104, 32'h3100, imem(32'h3100), 0, 0, 4);
        add(0, 1, 0, 1, 32'h3200,     32'h3104, 32'h3100, imem(32'h3100), 0, 0, 4);
        add(0, 0, 0, 1, 32'h3200,     32'h3200, 32'h3104, imem(32'h3104), 0, 0, 5);
        add(0, 0, 0, 0, 32'h0,        32'h3204, 32'h3200, imem(32'h3200), 0, 0, 6);
        add(0, 0, 0, 1, 32'h3013,     32'h3010, 32'h3204, imem(32'h3204), 0, 0, 7);
        add(0, 0, 1, 0, 32'h0,        32'h3010, 32'h3204, 32'h0,         1, 1, 7);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 32'h3300, 32'h3010, 32'h3204, 32'h0,         1, 1, 7);
        add(1, 1, 0, 1, 32'h3300,     32'h3000, 32'h3000, 32'h0,         1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h3004, 32'h3000, 32'h11,        0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].hlt, vecs[i].rdr, vecs[i].tgt);
            chk($sformatf("vec%0d.imemAddr", i), a_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d.pcD", i), a_pcd, vecs[i].e_pcd);
            chk($sformatf("vec%0d.pc8D", i), a_pc8, vecs[i].e_pcd + 32'd8);
            chk($sformatf("vec%0d.instrD", i), a_instr, vecs[i].e_instr);
            chk($sformatf("vec%0d.bubbleD", i), 32'(a_bub), 32'(vecs[i].e_bub));
            chk($sformatf("vec%0d.halted", i), 32'(a_halted), 32'(vecs[i].e_halted));
            chk($sformatf("vec%0d.fetchCount", i), a_cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d.imemRangeErr", i), 32'(a_err), 32'h0);
        end

        // Small instruction memory: fetch from 0x3010 is out of range
        drive(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 32'h0);
        chk("range.pre_err", 32'(b_err), 32'h0);
        chk("range.pre_addr", b_addr, 32'h3010);
        chk("range.pre_cnt", b_cnt, 32'd4);
        drive(0, 0, 0, 0, 32'h0);
        chk("range.err", 32'(b_err), 32'h1);
        chk("range.bubble", 32'(b_bub), 32'h1);
        chk("range.instr", b_instr, 32'h0);
        chk("range.addr", b_addr, 32'h3014);
        chk("range.cnt", b_cnt, 32'd4);

        // Wrap at the top of the address space, unaligned target bits dropped
        drive(1, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap.redirect_addr", a_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0);
        chk("wrap.addr", a_addr, 32'h0000_0000);
        chk("wrap.pcD", a_pcd, 32'hFFFF_FFFC);
        chk("wrap.pc8D", a_pc8, 32'h0000_0004);

        // Randomized run against the reference model on both instances
        for (int c = 0; c < 600; c++) begin
            logic        rst, stl, hlt, rdr;
            logic [31:0] tgt;
            int unsigned sel;
            rst = (c == 0) || ($urandom_range(0, 49) == 0);
            stl = ($urandom_range(0, 3) == 0);
            hlt = ($urandom_range(0, 39) == 0);
            rdr = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      tgt = RPC + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            else if (sel < 8) tgt = RPC + 4 * $urandom_range(0, 2000);
            else if (sel < 9) tgt = $urandom;
            else              tgt = 32'hFFFF_FFFC;
            m_a = model_step(m_a, rst, stl, hlt, rdr, tgt, 1024);
            m_b = model_step(m_b, rst, stl, hlt, rdr, tgt, 4);
            drive(rst, stl, hlt, rdr, tgt);
            cmp("rand_a", m_a, a_addr, a_instr, a_pcd, a_pc8, a_bub, a_halted, a_cnt, a_err);
            cmp("rand_b", m_b, b_addr, b_instr, b_pcd, b_pc8, b_bub, b_halted, b_cnt, b_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
